// File: rtl/mmio_timer_responder_pkg.sv
// Shared definitions for the MMIO timer responder: default window base,
// register offsets inside the 8-word window, CTRL bit positions and the
// packed CTRL register layout.
package mmio_timer_responder_pkg;

  localparam logic [6:0] DEFAULT_BASE = 7'h78;

  // Register offsets (ADDR[2:0]); offsets 5-7 are unimplemented.
  localparam logic [2:0] OFS_LED   = 3'd0;
  localparam logic [2:0] OFS_SW    = 3'd1;
  localparam logic [2:0] OFS_COUNT = 3'd2;
  localparam logic [2:0] OFS_CMP   = 3'd3;
  localparam logic [2:0] OFS_CTRL  = 3'd4;

  // CTRL bit positions.
  localparam int CTRL_EN         = 0;
  localparam int CTRL_MATCH      = 1;
  localparam int CTRL_AUTORELOAD = 2;
  localparam int CTRL_IE         = 3;

  // Field order gives ie=bit3, autoreload=bit2, match=bit1, en=bit0.
  typedef struct packed {
    logic ie;
    logic autoreload;
    logic match;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    return {28'h0, c};
  endfunction

endpackage

// File: rtl/mmio_timer_responder_sync_ff.sv
// Single-bit synchronizer of configurable depth for an asynchronous input.
// Ports:
//   CLK  in  clock
//   RST  in  synchronous active-high reset, clears every stage
//   d    in  asynchronous input bit
//   q    out synchronized bit, DEPTH cycles of latency
module mmio_timer_responder_sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the value its neighbour held before the edge.
  always_ff @(posedge CLK) begin
    if (RST) stages <= '0;
    else     stages <= {stages[DEPTH-2:0], d};
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/mmio_timer_responder.sv
// Memory-mapped responder occupying an 8-word window of the 7-bit word
// address space. Provides LED, synchronized switch, 32-bit timer, compare
// and control registers with the same bus timing as the RAM.
// Ports:
//   CLK      in    clock
//   RST      in    synchronous active-high reset
//   CS, WE   in    bus chip select / write enable from the CPU
//   ADDR     in    7-bit word address
//   Mem_Bus  inout 32-bit shared data bus, driven only on a window read
//   SW       in    8 asynchronous switch inputs
//   LED      out   LED register
//   HIT      out   combinational window decode (CS & match)
//   IRQ      out   CTRL.IE & CTRL.MATCH
module mmio_timer_responder
  import mmio_timer_responder_pkg::*;
#(
  parameter logic [6:0] BASE        = DEFAULT_BASE,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        WE,
  input  logic [6:0]  ADDR,
  inout  tri   [31:0] Mem_Bus,
  input  logic [7:0]  SW,
  output logic [7:0]  LED,
  output logic        HIT,
  output logic        IRQ
);

  logic [7:0]  led_q;
  logic [7:0]  sw_sync;
  logic [31:0] count_q, count_next;
  logic [31:0] cmp_q;
  ctrl_t       ctrl_q, ctrl_next;
  logic [31:0] rd_mux;
  logic [31:0] data_q;
  logic [2:0]  ofs;
  logic        wr_en;
  logic        cmp_hit;

  assign ofs     = ADDR[2:0];
  assign HIT     = CS & (ADDR[6:3] == BASE[6:3]);
  assign wr_en   = CS & WE & HIT;
  assign cmp_hit = ctrl_q.en & (count_q == cmp_q);

  for (genvar i = 0; i < 8; i++) begin : g_sync
    mmio_timer_responder_sync_ff #(.DEPTH(SYNC_STAGES)) u_sync (
      .CLK (CLK),
      .RST (RST),
      .d   (SW[i]),
      .q   (sw_sync[i])
    );
  end

  // Timer: a bus write to COUNT overrides the increment/reload.
  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    count_next = count_q;
    if (ctrl_q.en) count_next = (cmp_hit && ctrl_q.autoreload) ? 32'd0 : count_q + 32'd1;
    if (wr_en && ofs == OFS_COUNT) count_next = Mem_Bus;
  end

  // CTRL: MATCH set by the comparator wins over a same-cycle W1C.
  always_comb begin
    ctrl_next       = ctrl_q;
    ctrl_next.match = ctrl_q.match | cmp_hit;
    if (wr_en && ofs == OFS_CTRL) begin
      ctrl_next.en         = Mem_Bus[CTRL_EN];
      ctrl_next.autoreload = Mem_Bus[CTRL_AUTORELOAD];
      ctrl_next.ie         = Mem_Bus[CTRL_IE];
      ctrl_next.match      = cmp_hit | (ctrl_q.match & ~Mem_Bus[CTRL_MATCH]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      led_q   <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      if (wr_en && ofs == OFS_LED) led_q <= Mem_Bus[7:0];
      if (wr_en && ofs == OFS_CMP) cmp_q <= Mem_Bus;
      count_q <= count_next;
      ctrl_q  <= ctrl_next;
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    case (ofs)
      OFS_LED:   rd_mux = {24'h0, led_q};
      OFS_SW:    rd_mux = {24'h0, sw_sync};
      OFS_COUNT: rd_mux = count_q;
      OFS_CMP:   rd_mux = cmp_q;
      OFS_CTRL:  rd_mux = ctrl_word(ctrl_q);
      default:   rd_mux = 32'h0;
    endcase
  end

  // Read data is captured mid-cycle so it is stable by the CPU's capturing
  // posedge for both single-cycle fetches and two-cycle loads.
  always_ff @(negedge CLK) begin
    if (RST) data_q <= '0;
    else     data_q <= rd_mux;
  end

  assign Mem_Bus = (CS & ~WE & HIT) ? data_q : 32'bz;
  assign LED     = led_q;
  assign IRQ     = ctrl_q.ie & ctrl_q.match;

endmodule
